cke_ratio_generator: RTL and testbench

CKE_RATIO_GENERATOR -- requirements
Module: cke_ratio_generator

---
 rtl/cke_ratio_gen_pkg.sv | 23 ++
 rtl/cke_ratio_generator_cke_channel.sv | 30 +++
 rtl/cke_ratio_generator.sv | 147 ++++++++++++++
 tb/tb_cke_ratio_generator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cke_ratio_gen_pkg.sv
// Shared definitions for the clock-enable ratio generator.
// Holds the controller state enumeration and the divide-ratio clamp helper.
package cke_ratio_gen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Divide ratio minus one is kept within [1, max_m1]; a ratio of 1
  // would leave no room for a clock-enable phase pattern.
  function automatic int unsigned clamp_ratio_m1(input int unsigned raw_m1,
                                                 input int unsigned max_m1);
    if (raw_m1 == 0)
      return 1;
    else if (raw_m1 > max_m1)
      return max_m1;
    else
      return raw_m1;
  endfunction

endpackage

// File: rtl/cke_ratio_generator_cke_channel.sv
// One clock-enable channel: pulses cke for one cycle after an edge at which
// the divider phase matches this channel's offset while running.
// Ports:
//   clk    - logic clock
//   rst    - asynchronous active-high reset
//   run    - divider is running this cycle
//   phase  - current divider phase
//   offset - phase at which this channel fires
//   cke    - registered one-cycle enable pulse
module cke_channel #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [CW-1:0] phase,
  input  logic [CW-1:0] offset,
  output logic          cke
);

  // The phase never exceeds the active ratio, so an offset beyond it
  // simply never matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cke <= 1'b0;
    else
      cke <= run && (phase == offset);
  end

endmodule

// File: rtl/cke_ratio_generator.sv
// Divided logic clock and clock-enable generator, gated on DCM lock.
// Ports:
//   int_logic_drm_clock - the single clock, all state on its rising edge
//   int_reset           - asynchronous active-high reset
//   dcm_locked          - lock status of the upstream DCM
//   ratio_m1            - requested divide ratio minus 1
//   ratio_load          - one-cycle strobe capturing ratio_m1
//   cke_offset          - per-channel firing phase, channel i at [i*CW +: CW]
//   divided_clock       - registered divided clock
//   cke                 - registered one-cycle enable pulses per channel
//   phase               - current divider phase
//   ready               - high while running
//   ratio_ack           - one-cycle pulse after a new ratio takes effect
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_WAIT_LOCK | DCM not locked; outputs held at 0
// ST_SETTLE    | locked, counting down the settle time
// ST_RUN       | divider running, enables firing
module cke_ratio_generator
  import cke_ratio_gen_pkg::*;
#(
  parameter int MAX_RATIO      = 8,
  parameter int NUM_CKE        = 2,
  parameter int LOCK_WAIT      = 16,
  parameter int RESET_RATIO_M1 = 7,
  localparam int CW            = $clog2(MAX_RATIO)
) (
  input  logic                  int_logic_drm_clock,
  input  logic                  int_reset,
  input  logic                  dcm_locked,
  input  logic [CW-1:0]         ratio_m1,
  input  logic                  ratio_load,
  input  logic [NUM_CKE*CW-1:0] cke_offset,
  output logic                  divided_clock,
  output logic [NUM_CKE-1:0]    cke,
  output logic [CW-1:0]         phase,
  output logic                  ready,
  output logic                  ratio_ack
);

  localparam int SW = $clog2(LOCK_WAIT + 1);
  // The edge that first sees lock counts as one of the LOCK_WAIT cycles,
  // so the settle counter covers the remaining LOCK_WAIT-1 edges.
  localparam int SETTLE_LOAD = (LOCK_WAIT > 1) ? LOCK_WAIT - 2 : 0;
  localparam logic [CW:0] ONE_W = (CW + 1)'(1);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] ratio_active;
  logic [CW-1:0] ratio_pend;
  logic          pend_valid;
  logic          run_now;
  logic          wrap;
  logic [CW:0]   half_period;

  // Losing lock takes effect at the same edge, so the run qualifier
  // already includes dcm_locked.
  assign run_now     = (state == ST_RUN) && dcm_locked;
  assign wrap        = run_now && (phase == ratio_active);
  assign half_period = ({1'b0, ratio_active} + ONE_W) >> 1;

  always_ff @(posedge int_logic_drm_clock or posedge int_reset) begin
    if (int_reset) begin
      state         <= ST_WAIT_LOCK;
      settle_cnt    <= '0;
      ratio_active  <= CW'(RESET_RATIO_M1);
      ratio_pend    <= CW'(RESET_RATIO_M1);
      pend_valid    <= 1'b0;
      phase         <= '0;
      divided_clock <= 1'b0;
      ready         <= 1'b0;
      ratio_ack     <= 1'b0;
    end else begin
      ratio_ack <= 1'b0;

      // A load coinciding with the wrap re-arms the pending flag, so it
      // waits for the next wrap while the older pending value applies now.
      if (ratio_load) begin
        ratio_pend <= CW'(clamp_ratio_m1(32'(ratio_m1), 32'(MAX_RATIO - 1)));
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end

      if (wrap && pend_valid) begin
        ratio_active <= ratio_pend;
        ratio_ack    <= 1'b1;
      end

      // Uses the ratio in force before any wrap-edge update.
      divided_clock <= run_now && ({1'b0, phase} < half_period);

      if (!dcm_locked) begin
        state      <= ST_WAIT_LOCK;
        settle_cnt <= '0;
        phase      <= '0;
        ready      <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            phase <= '0;
            if (LOCK_WAIT > 1) begin
              state      <= ST_SETTLE;
              settle_cnt <= SW'(SETTLE_LOAD);
              ready      <= 1'b0;
            end else begin
              state <= ST_RUN;
              ready <= 1'b1;
            end
          end
          ST_SETTLE: begin
            phase <= '0;
            if (settle_cnt == '0) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          ST_RUN: begin
            ready <= 1'b1;
            phase <= wrap ? '0 : phase + CW'(1);
          end
          default: begin
            state      <= ST_WAIT_LOCK;
            settle_cnt <= '0;
            phase      <= '0;
            ready      <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CKE; i++) begin : g_chan
    cke_channel #(.CW(CW)) u_chan (
      .clk    (int_logic_drm_clock),
      .rst    (int_reset),
      .run    (run_now),
      .phase  (phase),
      .offset (cke_offset[i*CW +: CW]),
      .cke    (cke[i])
    );
  end

endmodule

// File: tb/tb_cke_ratio_generator.sv
module tb_cke_ratio_generator;

  localparam int MAX_RATIO = 8;
  localparam int NUM_CKE   = 2;
  localparam int LOCK_WAIT = 16;
  localparam int RESET_M1  = 7;
  localparam int CW        = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  locked;
  logic [CW-1:0]         rm1;
  logic                  load;
  logic [NUM_CKE*CW-1:0] offs;
  logic                  div;
  logic [NUM_CKE-1:0]    cke;
  logic [CW-1:0]         phase;
  logic                  ready;
  logic                  ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cke_ratio_generator #(
    .MAX_RATIO(MAX_RATIO), .NUM_CKE(NUM_CKE),
    .LOCK_WAIT(LOCK_WAIT), .RESET_RATIO_M1(RESET_M1)
  ) dut (
    .int_logic_drm_clock(clk), .int_reset(rst), .dcm_locked(locked),
    .ratio_m1(rm1), .ratio_load(load), .cke_offset(offs),
    .divided_clock(div), .cke(cke), .phase(phase),
    .ready(ready), .ratio_ack(ack)
  );

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model in terms of periods (N = ratio) and position within
  // the period; RUN is "at least LOCK_WAIT consecutive locked samples".
  int lock_run;
  int m_period, m_pend_period, m_pos, m_prev;
  bit m_pend_v, m_run, m_wrap;
  int e_phase;
  bit e_div, e_ready, e_ack;
  bit [NUM_CKE-1:0] e_cke;

  function automatic int clamp_n(input int raw_m1);
    int n;
    n = raw_m1 + 1;
    if (n < 2) n = 2;
    if (n > MAX_RATIO) n = MAX_RATIO;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_run = 0; m_period = RESET_M1 + 1; m_pend_period = RESET_M1 + 1;
      m_pend_v = 0; m_pos = 0;
      e_phase = 0; e_div = 0; e_ready = 0; e_ack = 0; e_cke = '0;
    end else begin
      m_prev   = lock_run;
      m_run    = (m_prev >= LOCK_WAIT) && (locked === 1'b1);
      lock_run = (locked === 1'b1) ? ((m_prev < LOCK_WAIT) ? m_prev + 1 : LOCK_WAIT) : 0;
      e_ready  = (lock_run >= LOCK_WAIT);
      m_wrap   = m_run && (m_pos == m_period - 1);
      e_ack    = m_wrap && m_pend_v;
      e_div    = m_run && (m_pos < m_period / 2);
      for (int i = 0; i < NUM_CKE; i++)
        e_cke[i] = m_run && (m_pos == int'(offs[i*CW +: CW]));
      if (m_wrap && m_pend_v) m_period = m_pend_period;
      if (load === 1'b1) begin
        m_pend_period = clamp_n(int'(rm1));
        m_pend_v = 1;
      end else if (m_wrap) begin
        m_pend_v = 0;
      end
      if (!m_run || m_wrap) m_pos = 0;
      else m_pos = m_pos + 1;
      e_phase = m_pos;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check_int("phase", int'(phase), e_phase);
      check_int("cke", int'(cke), int'(e_cke));
      check_int("divided_clock", int'(div), int'(e_div));
      check_int("ready", int'(ready), int'(e_ready));
      check_int("ratio_ack", int'(ack), int'(e_ack));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int val);
    int n;
    n = 0;
    while (int'(phase) != val && n < 40) begin
      tick();
      n++;
    end
    check_int("wait_phase", int'(phase), val);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (ack !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_int("ack_seen", int'(ack), 1);
  endtask

  task automatic load_ratio(input int m1);
    load = 1'b1;
    rm1  = CW'(m1);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_int(name, n, LOCK_WAIT);
    check_int({name, "_phase"}, int'(phase), 0);
  endtask

  int n, c0a, c0b, c1a, acks, hi, zeros, maxph, c;

  initial begin
    rst = 1'b0; locked = 1'b0; load = 1'b0; rm1 = '0;
    offs = {3'd2, 3'd0};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_outputs", int'({ready, ack, div, cke, phase}), 0);
    rst = 1'b0;

    // Lock 3 cycles after reset; ready 16 cycles later.
    repeat (3) tick();
    locked = 1'b1;
    wait_ready("ready_latency");

    // Ratio 8, offsets {0,2}.
    c0a = -1; c0b = -1; c1a = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cke[0] === 1'b1) begin
        if (c0a < 0) c0a = i;
        else if (c0b < 0) c0b = i;
      end
      if (cke[1] === 1'b1 && c1a < 0 && c0a >= 0) c1a = i;
    end
    check_int("cke0_period", c0b - c0a, 8);
    check_int("cke1_lag", c1a - c0a, 2);

    // Load ratio 4 at phase 3: period 8 finishes first.
    wait_phase(3);
    load_ratio(3);
    n = 0;
    while (int'(phase) != 0 && n < 20) begin
      tick();
      n++;
    end
    check_int("period8_tail", n, 4);
    check_int("ack_at_wrap", int'(ack), 1);
    acks = 0; hi = 0; maxph = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      acks += int'(ack);
      hi += int'(div);
      if (int'(phase) > maxph) maxph = int'(phase);
    end
    check_int("no_extra_ack", acks, 0);
    check_int("ratio4_high", hi, 4);
    check_int("ratio4_max_phase", maxph, 3);

    // Offset 5 at ratio 4 never fires; newest of two loads wins.
    offs = {3'd5, 3'd0};
    c = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      c += int'(cke[1]);
    end
    check_int("offset_beyond_ratio", c, 0);
    wait_phase(0);
    load = 1'b1; rm1 = 3'd2;
    tick();
    rm1 = 3'd7;
    tick();
    load = 1'b0;
    acks = 0; c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acks += int'(ack);
      if (i >= 2 && i < 18) c += int'(cke[1]);
    end
    check_int("newest_wins_ack", acks, 1);
    check_int("offset5_fires", c, 2);

    // Clamp: ratio_m1=0 gives period 2.
    load_ratio(0);
    wait_ack();
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      zeros += (int'(phase) == 0) ? 1 : 0;
    end
    check_int("clamp_period2", zeros, 4);

    // Ratio 3: one high, two low.
    load_ratio(2);
    wait_ack();
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      hi += int'(div);
    end
    check_int("ratio3_high", hi, 3);

    // Lock loss and relock; a load while unlocked applies on first wrap.
    load_ratio(7);
    wait_ack();
    locked = 1'b0;
    tick();
    check_int("unlock_outputs", int'({ready, ack, div, cke, phase}), 0);
    load_ratio(5);
    repeat (2) tick();
    locked = 1'b1;
    wait_ready("relock_latency");
    n = 0;
    while (ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_int("first_wrap_after_relock", n, 8);
    n = 0;
    do begin
      tick();
      n++;
    end while (int'(phase) != 0 && n < 20);
    check_int("period6_after_relock", n, 6);

    // Asynchronous reset between edges.
    n = 0;
    while (div !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_int("div_high_before_reset", int'(div), 1);
    #2 rst = 1'b1;
    #1;
    check_int("async_reset_outputs", int'({ready, ack, div, cke, phase}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ready("ready_after_reset");
    n = 0;
    do begin
      tick();
      n++;
    end while (int'(phase) != 0 && n < 20);
    check_int("reset_ratio_period", n, 8);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
